// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: select encoding and its one-hot decode.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRZR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET,
    SEL_ILLEGAL
  } sel_e;

  // Anything other than zero or exactly one active select is illegal.
  function automatic sel_e decode_sel(input logic brzr, input logic jmp,
                                      input logic call, input logic ret);
    sel_e sel;
    case ({ret, call, jmp, brzr})
      4'b0000: sel = SEL_SEQ;
      4'b0001: sel = SEL_BRZR;
      4'b0010: sel = SEL_JMP;
      4'b0100: sel = SEL_CALL;
      4'b1000: sel = SEL_RET;
      default: sel = SEL_ILLEGAL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; pushes when full and pops when empty are silently ignored.
module ret_stack #(
  parameter int BITS        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [BITS-1:0] din,
  output logic [BITS-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [BITS-1:0] mem [STACK_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_next;

  always_comb begin
    ptr_next = ptr;
    if (push && !full)
      ptr_next = ptr + PW'(1);
    else if (pop && !empty)
      ptr_next = ptr - PW'(1);
  end

  // Flags are registered from the next pointer so they line up with ptr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      ptr   <= ptr_next;
      empty <= (ptr_next == '0);
      full  <= (ptr_next == PW'(STACK_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !full)
      mem[IW'(ptr)] <= din;
  end

  assign top = empty ? '0 : mem[IW'(ptr - PW'(1))];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, next-PC selection, return stack and error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              BITS         = 8,
  parameter int              STACK_DEPTH  = 4,
  parameter logic [BITS-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            brzr_sel,
  input  logic            jmp_sel,
  input  logic            call_sel,
  input  logic            ret_sel,
  input  logic [BITS-1:0] pc_brzr,
  input  logic [BITS-1:0] pc_jmp,
  output logic [BITS-1:0] pc,
  output logic [BITS-1:0] next_pc,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            sel_err,
  output logic            stack_err
);

  sel_e            sel;
  logic [BITS-1:0] seq;
  logic [BITS-1:0] stack_top;
  logic            push;
  logic            pop;
  logic            sel_err_c;
  logic            stack_err_set;

  assign seq = pc + BITS'(INC);
  assign sel = decode_sel(brzr_sel, jmp_sel, call_sel, ret_sel);

  // Stall freezes everything and suppresses both error sources.
  always_comb begin
    next_pc       = seq;
    push          = 1'b0;
    pop           = 1'b0;
    sel_err_c     = 1'b0;
    stack_err_set = 1'b0;
    if (stall) begin
      next_pc = pc;
    end else begin
      case (sel)
        SEL_BRZR: next_pc = pc_brzr;
        SEL_JMP:  next_pc = pc_jmp;
        SEL_CALL: begin
          next_pc = pc_jmp;
          if (stack_full) stack_err_set = 1'b1;
          else            push          = 1'b1;
        end
        SEL_RET: begin
          if (stack_empty) begin
            stack_err_set = 1'b1;
          end else begin
            next_pc = stack_top;
            pop     = 1'b1;
          end
        end
        SEL_ILLEGAL: sel_err_c = 1'b1;
        default:     next_pc = seq;
      endcase
    end
  end

  assign sel_err = sel_err_c & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n)
      pc <= RESET_VECTOR;
    else
      pc <= next_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stack_err <= 1'b0;
    else if (stack_err_set)
      stack_err <= 1'b1;
  end

  ret_stack #(
    .BITS        (BITS),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (seq),
    .top   (stack_top),
    .empty (stack_empty),
    .full  (stack_full)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test of pc_sequencer with BITS=8, STACK_DEPTH=4, RESET_VECTOR=0x10.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic       brzr_sel;
  logic       jmp_sel;
  logic       call_sel;
  logic       ret_sel;
  logic [7:0] pc_brzr;
  logic [7:0] pc_jmp;
  logic [7:0] pc;
  logic [7:0] next_pc;
  logic       stack_empty;
  logic       stack_full;
  logic       sel_err;
  logic       stack_err;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(
    .BITS         (8),
    .STACK_DEPTH  (4),
    .RESET_VECTOR (8'h10),
    .INC          (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .brzr_sel    (brzr_sel),
    .jmp_sel     (jmp_sel),
    .call_sel    (call_sel),
    .ret_sel     (ret_sel),
    .pc_brzr     (pc_brzr),
    .pc_jmp      (pc_jmp),
    .pc          (pc),
    .next_pc     (next_pc),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .sel_err     (sel_err),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's worth of inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic r, input logic s, input logic b, input logic j,
                               input logic c, input logic t, input logic [7:0] tb_brzr,
                               input logic [7:0] tb_jmp);
    rst_n = r; stall = s; brzr_sel = b; jmp_sel = j; call_sel = c; ret_sel = t;
    pc_brzr = tb_brzr; pc_jmp = tb_jmp;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic doCall(input logic [7:0] target);
    applyStimulus(1, 0, 0, 0, 1, 0, 8'h00, target);
    step();
  endtask

  task automatic doJump(input logic [7:0] target);
    applyStimulus(1, 0, 0, 1, 0, 0, 8'h00, target);
    step();
  endtask

  initial begin
    logic [7:0] ret_exp [4];
    ret_exp[0] = 8'h81; ret_exp[1] = 8'h71; ret_exp[2] = 8'h61; ret_exp[3] = 8'h12;

    // Reset with conflicting selects held high
    applyStimulus(0, 0, 1, 1, 0, 0, 8'h40, 8'h05);
    checkOutput("sel_err_in_reset", sel_err, 0);
    step();
    checkOutput("rst_pc", pc, 8'h10);
    checkOutput("rst_empty", stack_empty, 1);
    checkOutput("rst_full", stack_full, 0);
    checkOutput("rst_stack_err", stack_err, 0);

    // Sequential run
    idle();
    checkOutput("seq_next_pc", next_pc, 8'h11);
    step();
    checkOutput("seq_pc1", pc, 8'h11);
    step();
    checkOutput("seq_pc2", pc, 8'h12);

    // Wrap-around
    doJump(8'hFF);
    checkOutput("jmp_ff", pc, 8'hFF);
    idle();
    checkOutput("wrap_next_pc", next_pc, 8'h00);
    step();
    checkOutput("wrap_pc", pc, 8'h00);

    // Branch then jump
    doJump(8'h20);
    applyStimulus(1, 0, 1, 0, 0, 0, 8'h40, 8'h00);
    checkOutput("brzr_next_pc", next_pc, 8'h40);
    step();
    checkOutput("brzr_pc", pc, 8'h40);
    doJump(8'h05);
    checkOutput("jmp_pc", pc, 8'h05);

    // Nested call/return
    doJump(8'h10);
    doCall(8'h30);
    checkOutput("call1_pc", pc, 8'h30);
    checkOutput("call1_empty", stack_empty, 0);
    doCall(8'h50);
    checkOutput("call2_pc", pc, 8'h50);
    applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    checkOutput("ret1_next_pc", next_pc, 8'h31);
    step();
    checkOutput("ret1_pc", pc, 8'h31);
    applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    step();
    checkOutput("ret2_pc", pc, 8'h11);
    checkOutput("nest_empty", stack_empty, 1);
    checkOutput("nest_stack_err", stack_err, 0);

    // Overflow: four pushes of 0x12,0x61,0x71,0x81, then a dropped fifth
    doCall(8'h60);
    doCall(8'h70);
    doCall(8'h80);
    doCall(8'h90);
    checkOutput("fill_full", stack_full, 1);
    checkOutput("fill_stack_err", stack_err, 0);
    doCall(8'hA0);
    checkOutput("ovf_pc", pc, 8'hA0);
    checkOutput("ovf_full", stack_full, 1);
    checkOutput("ovf_stack_err", stack_err, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
      step();
      checkOutput($sformatf("unwind_pc%0d", i), pc, ret_exp[i]);
    end
    checkOutput("unwind_empty", stack_empty, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    checkOutput("udf_next_pc", next_pc, 8'h13);
    step();
    checkOutput("udf_pc", pc, 8'h13);
    checkOutput("udf_stack_err", stack_err, 1);
    checkOutput("udf_empty", stack_empty, 1);

    // Select conflict
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h40, 8'h05);
    checkOutput("conflict_sel_err", sel_err, 1);
    checkOutput("conflict_next_pc", next_pc, 8'h14);
    step();
    checkOutput("conflict_pc", pc, 8'h14);
    idle();
    checkOutput("conflict_clear", sel_err, 0);

    // Stall with a call (and once with a conflict) must not move anything
    doCall(8'h30);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 1, (i == 1), 8'h00, 8'h77);
      checkOutput($sformatf("stall_next_pc%0d", i), next_pc, 8'h30);
      checkOutput($sformatf("stall_sel_err%0d", i), sel_err, 0);
      step();
      checkOutput($sformatf("stall_pc%0d", i), pc, 8'h30);
    end
    checkOutput("stall_empty", stack_empty, 0);
    checkOutput("stall_full", stack_full, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    checkOutput("stall_ret_next_pc", next_pc, 8'h15);
    step();
    checkOutput("stall_ret_pc", pc, 8'h15);
    checkOutput("stall_ret_empty", stack_empty, 1);

    // Reset mid-operation with two entries stacked and stall high
    doCall(8'h40);
    doCall(8'h50);
    checkOutput("pre_rst_empty", stack_empty, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 8'h00, 8'h99);
    step();
    checkOutput("mid_rst_pc", pc, 8'h10);
    checkOutput("mid_rst_empty", stack_empty, 1);
    checkOutput("mid_rst_stack_err", stack_err, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    checkOutput("post_rst_ret_next_pc", next_pc, 8'h11);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
